// File: rtl/led_slot_scheduler.sv
// Round-robin time-slot owner of the LED bank.
// Fixed-length slots separated by a blanking gap.
module led_slot_scheduler #(
  parameter int NREQ      = 4,
  parameter int BITS      = 5,
  parameter int LOG2DELAY = 22,
  parameter int GAP       = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*BITS-1:0] pattern,
  output logic [NREQ-1:0]      grant,
  output logic [BITS-1:0]      leds,
  output logic                 slot_done
);

  localparam int LW = $clog2(NREQ);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLANK
  } state_e;

  state_e                 state_q, state_d;
  logic [NREQ-1:0]        grant_q, grant_d;
  logic [BITS-1:0]        leds_q, leds_d;
  logic                   done_q, done_d;
  logic [LOG2DELAY-1:0]   timer_q, timer_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [LW-1:0]          last_q, last_d;

  logic                   win_vld;
  logic [LW-1:0]          win_idx;
  logic [NREQ-1:0]        win_oh;
  logic [BITS-1:0]        sel_pat;
  logic                   slot_end;
  logic                   gap_last;

  // Round-robin search starting just after the last owner
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = int'(last_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_idx = LW'(idx);
      end
    end
    win_oh = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
  end

  // Pattern slice of the current owner
  always_comb begin
    sel_pat = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (last_q == LW'(i)) sel_pat = pattern[i*BITS +: BITS];
    end
  end

  assign slot_end = !req[last_q] ||
                    (timer_q == {LOG2DELAY{1'b1}});
  assign gap_last = (gap_q == GW'(GAP - 1));

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    leds_d  = '0;
    done_d  = 1'b0;
    timer_d = timer_q;
    gap_d   = gap_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (win_vld) begin
          state_d = SHOW;
          grant_d = win_oh;
          last_d  = win_idx;
          timer_d = '0;
        end
      end
      SHOW: begin
        if (slot_end) begin
          state_d = BLANK;
          grant_d = '0;
          done_d  = 1'b1;
          gap_d   = '0;
          timer_d = '0;
        end else begin
          leds_d  = sel_pat;
          timer_d = timer_q + 1'b1;
        end
      end
      BLANK: begin
        grant_d = '0;
        if (gap_last) begin
          if (win_vld) begin
            state_d = SHOW;
            grant_d = win_oh;
            last_d  = win_idx;
            timer_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      leds_q  <= '0;
      done_q  <= 1'b0;
      timer_q <= '0;
      gap_q   <= '0;
      last_q  <= LW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      leds_q  <= leds_d;
      done_q  <= done_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
    end
  end

  assign grant     = grant_q;
  assign leds      = leds_q;
  assign slot_done = done_q;

endmodule

// File: tb/tb_led_slot_scheduler.sv
// Directed bench for led_slot_scheduler.
// Per-cycle vector table plus hand-written corner sequences.
module tb_led_slot_scheduler;

  localparam logic [4:0] P0 = 5'h15;
  localparam logic [4:0] P1 = 5'h0A;
  localparam logic [4:0] P2 = 5'h07;
  localparam logic [4:0] P3 = 5'h1C;

  logic        clk;
  logic        resetn;
  logic [3:0]  req;
  logic [19:0] pattern;
  logic [3:0]  grant;
  logic [4:0]  leds;
  logic        slot_done;

  int total;
  int bad;

  typedef struct {
    logic [3:0] req;
    logic [3:0] g;
    logic [4:0] l;
    logic       sd;
  } vec_t;

  vec_t tbl[$];

  led_slot_scheduler #(
    .NREQ(4),
    .BITS(5),
    .LOG2DELAY(3),
    .GAP(2)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .req(req),
    .pattern(pattern),
    .grant(grant),
    .leds(leds),
    .slot_done(slot_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm,
                         input logic [3:0] g,
                         input logic [4:0] l,
                         input logic sd);
    chk({nm, " grant"}, 32'(grant), 32'(g));
    chk({nm, " leds"}, 32'(leds), 32'(l));
    chk({nm, " slot_done"}, 32'(slot_done), 32'(sd));
    chk({nm, " onehot0"}, 32'($onehot0(grant)), 32'd1);
  endtask

  task automatic step(input logic [3:0] r,
                      input logic [3:0] g,
                      input logic [4:0] l,
                      input logic sd,
                      input string nm);
    req = r;
    @(posedge clk);
    #1;
    chk_out(nm, g, l, sd);
  endtask

  // One full slot: 8 SHOW cycles (leds lag grant by one) then 2 BLANK
  task automatic add_slot(input logic [3:0] r,
                          input logic [3:0] g,
                          input logic [4:0] l);
    tbl.push_back('{r, g, 5'h00, 1'b0});
    for (int i = 0; i < 7; i++) tbl.push_back('{r, g, l, 1'b0});
    tbl.push_back('{r, 4'b0000, 5'h00, 1'b1});
    tbl.push_back('{r, 4'b0000, 5'h00, 1'b0});
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    pattern = {P3, P2, P1, P0};

    add_slot(4'b0001, 4'b0001, P0);
    add_slot(4'b0001, 4'b0001, P0);
    add_slot(4'b1011, 4'b0010, P1);
    add_slot(4'b1011, 4'b1000, P3);
    add_slot(4'b1011, 4'b0001, P0);

    // Reset held with all requests up
    resetn = 1'b0;
    req    = 4'hF;
    #2;
    chk_out("rst_async", 4'b0000, 5'h00, 1'b0);
    @(posedge clk);
    #1;
    chk_out("rst_held", 4'b0000, 5'h00, 1'b0);
    resetn = 1'b1;
    step(4'hF, 4'b0001, 5'h00, 1'b0, "rst_first_grant");

    // Clean restart, then idle with no requests
    resetn = 1'b0;
    #1;
    chk_out("rst_again", 4'b0000, 5'h00, 1'b0);
    #2;
    resetn = 1'b1;
    step(4'b0000, 4'b0000, 5'h00, 1'b0, "idle0");
    step(4'b0000, 4'b0000, 5'h00, 1'b0, "idle1");

    // Full slots and round robin
    foreach (tbl[i]) begin
      step(tbl[i].req, tbl[i].g, tbl[i].l, tbl[i].sd,
           $sformatf("vec%0d", i));
    end

    // Early release: owner 1 drops during timer=3
    step(4'b0110, 4'b0010, 5'h00, 1'b0, "er_grant");
    step(4'b0110, 4'b0010, P1, 1'b0, "er_t1");
    step(4'b0110, 4'b0010, P1, 1'b0, "er_t2");
    step(4'b0110, 4'b0010, P1, 1'b0, "er_t3");
    step(4'b0100, 4'b0000, 5'h00, 1'b1, "er_end");
    step(4'b0100, 4'b0000, 5'h00, 1'b0, "er_blank");
    step(4'b0100, 4'b0100, 5'h00, 1'b0, "er_next");

    // Drop coincident with terminal count; late req in BLANK wins
    for (int t = 1; t <= 7; t++) begin
      step(4'b0100, 4'b0100, P2, 1'b0, $sformatf("co_t%0d", t));
    end
    step(4'b0000, 4'b0000, 5'h00, 1'b1, "co_end");
    step(4'b0000, 4'b0000, 5'h00, 1'b0, "co_blank");
    step(4'b1000, 4'b1000, 5'h00, 1'b0, "co_late_win");

    // Async reset in the middle of a slot
    for (int t = 1; t <= 4; t++) begin
      step(4'b1000, 4'b1000, P3, 1'b0, $sformatf("ar_t%0d", t));
    end
    #3;
    resetn = 1'b0;
    #1;
    chk_out("ar_async", 4'b0000, 5'h00, 1'b0);
    step(4'hF, 4'b0000, 5'h00, 1'b0, "ar_held");
    resetn = 1'b1;
    step(4'hF, 4'b0001, 5'h00, 1'b0, "ar_regrant");
    step(4'hF, 4'b0001, P0, 1'b0, "ar_leds");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
